// File: rtl/frame_sequencer_pkg.sv
// Shared types and default timing for the frame sequencer.
package frame_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StExpose,
    StCntRst,
    StConvert,
    StRowSetup,
    StRowOffer,
    StDone
  } sequencer_state_t;

  localparam int unsigned ARRAY_HEIGHT_DEF   = 128;
  localparam int unsigned PIXEL_BITS_DEF     = 8;
  localparam int unsigned ERASE_CYCLES_DEF   = 5;
  localparam int unsigned EXPOSE_CYCLES_DEF  = 255;
  localparam int unsigned CONVERT_CYCLES_DEF = 2 ** PIXEL_BITS_DEF;
  localparam int unsigned ROW_ADDR_BITS      = $clog2(ARRAY_HEIGHT_DEF);

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_sequencer_phase_timer.sv
// Loadable down-counter shared by all timed phases; zero flag marks the last cycle.
module phase_timer #(
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/frame_sequencer.sv
// Frame controller: erase, expose, counter reset, convert, then handshaked row readout.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned ARRAY_HEIGHT   = ARRAY_HEIGHT_DEF,
  parameter int unsigned PIXEL_BITS     = PIXEL_BITS_DEF,
  parameter int unsigned ERASE_CYCLES   = ERASE_CYCLES_DEF,
  parameter int unsigned EXPOSE_CYCLES  = EXPOSE_CYCLES_DEF,
  parameter int unsigned CONVERT_CYCLES = 2 ** PIXEL_BITS
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic                            continuous_i,
  output logic                            erase_o,
  output logic                            expose_o,
  output logic                            counter_reset_o,
  output logic                            convert_o,
  output logic                            read_o,
  output logic [$clog2(ARRAY_HEIGHT)-1:0] row_select_o,
  output logic                            row_valid_o,
  input  logic                            row_accept_i,
  output logic                            busy_o,
  output logic                            frame_finished_o
);

  localparam int unsigned RowW = $clog2(ARRAY_HEIGHT);
  localparam int unsigned CntW = $clog2(max3(ERASE_CYCLES, EXPOSE_CYCLES, CONVERT_CYCLES)) + 1;
  localparam logic [RowW-1:0] LastRow = RowW'(ARRAY_HEIGHT - 1);

  if (ERASE_CYCLES < 1 || EXPOSE_CYCLES < 1 || CONVERT_CYCLES < 1 || ARRAY_HEIGHT < 2)
  begin : g_bad_param
    $error("frame_sequencer: cycle parameters must be >= 1 and ARRAY_HEIGHT >= 2");
  end

  sequencer_state_t state_q, state_d;
  logic [RowW-1:0]  row_q, row_d;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [CntW-1:0]  tmr_val;
  logic erase_q, expose_q, cnt_rst_q, convert_q, read_q, valid_q, busy_q, finished_q;

  phase_timer #(
    .Width (CntW)
  ) u_phase_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        row_d = '0;
        if (start_i) begin
          state_d  = StErase;
          tmr_load = 1'b1;
          tmr_val  = CntW'(ERASE_CYCLES - 1);
        end
      end
      StErase: begin
        if (tmr_zero) begin
          state_d  = StExpose;
          tmr_load = 1'b1;
          tmr_val  = CntW'(EXPOSE_CYCLES - 1);
        end else begin
          tmr_en = 1'b1;
        end
      end
      StExpose: begin
        if (tmr_zero) state_d = StCntRst;
        else          tmr_en  = 1'b1;
      end
      StCntRst: begin
        state_d  = StConvert;
        tmr_load = 1'b1;
        tmr_val  = CntW'(CONVERT_CYCLES - 1);
      end
      StConvert: begin
        if (tmr_zero) begin
          state_d = StRowSetup;
          row_d   = '0;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StRowSetup: state_d = StRowOffer;
      StRowOffer: begin
        if (row_accept_i) begin
          if (row_q == LastRow) begin
            state_d = StDone;
            row_d   = '0;
          end else begin
            state_d = StRowSetup;
            row_d   = row_q + RowW'(1);
          end
        end
      end
      StDone: begin
        row_d = '0;
        if (continuous_i) begin
          state_d  = StErase;
          tmr_load = 1'b1;
          tmr_val  = CntW'(ERASE_CYCLES - 1);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      row_q      <= '0;
      erase_q    <= 1'b0;
      expose_q   <= 1'b0;
      cnt_rst_q  <= 1'b0;
      convert_q  <= 1'b0;
      read_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      erase_q    <= (state_d == StErase);
      expose_q   <= (state_d == StExpose);
      cnt_rst_q  <= (state_d == StCntRst);
      convert_q  <= (state_d == StConvert);
      read_q     <= (state_d == StRowSetup) || (state_d == StRowOffer);
      valid_q    <= (state_d == StRowOffer);
      busy_q     <= (state_d != StIdle);
      finished_q <= (state_d == StDone);
    end
  end

  assign erase_o          = erase_q;
  assign expose_o         = expose_q;
  assign counter_reset_o  = cnt_rst_q;
  assign convert_o        = convert_q;
  assign read_o           = read_q;
  assign row_select_o     = row_q;
  assign row_valid_o      = valid_q;
  assign busy_o           = busy_q;
  assign frame_finished_o = finished_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected rows and frame timings, monitors pop and compare.
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  typedef struct {
    int len;
    int er;
    int ex;
    int cr;
    int cv;
  } frame_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, continuous = 1'b0, accept = 1'b1;
  logic erase, expose, cnt_rst, convert, read, valid, busy, finished;
  logic [ROW_ADDR_BITS-1:0] row_sel;

  logic s_start = 1'b0;
  logic s_erase, s_expose, s_cnt_rst, s_convert, s_read, s_valid, s_busy, s_finished;
  logic [0:0] s_row_sel;

  int checks = 0;
  int errors = 0;

  frame_exp_t exp_frames[$];
  int         exp_rows[$];
  frame_exp_t s_exp_frames[$];
  int         s_exp_rows[$];

  always #5 clk = ~clk;

  frame_sequencer dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .continuous_i     (continuous),
    .erase_o          (erase),
    .expose_o         (expose),
    .counter_reset_o  (cnt_rst),
    .convert_o        (convert),
    .read_o           (read),
    .row_select_o     (row_sel),
    .row_valid_o      (valid),
    .row_accept_i     (accept),
    .busy_o           (busy),
    .frame_finished_o (finished)
  );

  frame_sequencer #(
    .ARRAY_HEIGHT   (2),
    .ERASE_CYCLES   (1),
    .EXPOSE_CYCLES  (1),
    .CONVERT_CYCLES (1)
  ) dut_small (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (s_start),
    .continuous_i     (1'b0),
    .erase_o          (s_erase),
    .expose_o         (s_expose),
    .counter_reset_o  (s_cnt_rst),
    .convert_o        (s_convert),
    .read_o           (s_read),
    .row_select_o     (s_row_sel),
    .row_valid_o      (s_valid),
    .row_accept_i     (1'b1),
    .busy_o           (s_busy),
    .frame_finished_o (s_finished)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_frame(input string tag, input frame_exp_t e, input int len, input int er,
                           input int ex, input int cr, input int cv);
    check({tag, "_frame_len"}, len, e.len);
    check({tag, "_erase_cycles"}, er, e.er);
    check({tag, "_expose_cycles"}, ex, e.ex);
    check({tag, "_cnt_rst_cycles"}, cr, e.cr);
    check({tag, "_convert_cycles"}, cv, e.cv);
  endtask

  // Main DUT monitor
  int  done_cnt = 0;
  bit  in_frame = 0, prev_valid = 0;
  int  f_len, n_er, n_ex, n_cr, n_cv, prev_row;
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
    end else begin
      if (erase && !in_frame) begin
        in_frame = 1;
        f_len = 0; n_er = 0; n_ex = 0; n_cr = 0; n_cv = 0;
      end
      if (in_frame) begin
        f_len++;
        n_er += int'(erase); n_ex += int'(expose); n_cr += int'(cnt_rst); n_cv += int'(convert);
      end
      if (valid && accept) begin
        if (exp_rows.size() == 0) check("unexpected_row", 1, 0);
        else check("row_transfer", int'(row_sel), exp_rows.pop_front());
      end else if (valid && prev_valid) begin
        check("row_stable", int'(row_sel), prev_row);
      end
      prev_valid = valid;
      prev_row   = int'(row_sel);
      if (finished) begin
        if (exp_frames.size() == 0) check("unexpected_frame", 1, 0);
        else cmp_frame("main", exp_frames.pop_front(), f_len, n_er, n_ex, n_cr, n_cv);
        in_frame = 0;
        done_cnt++;
      end
    end
  end

  // Small-parameter DUT monitor
  int s_done_cnt = 0;
  bit s_in = 0;
  int s_len, s_er, s_ex, s_cr, s_cv;
  always @(negedge clk) begin
    if (!rst) begin
      if (s_erase && !s_in) begin
        s_in = 1;
        s_len = 0; s_er = 0; s_ex = 0; s_cr = 0; s_cv = 0;
      end
      if (s_in) begin
        s_len++;
        s_er += int'(s_erase); s_ex += int'(s_expose);
        s_cr += int'(s_cnt_rst); s_cv += int'(s_convert);
      end
      if (s_valid) begin
        if (s_exp_rows.size() == 0) check("small_unexpected_row", 1, 0);
        else check("small_row_transfer", int'(s_row_sel), s_exp_rows.pop_front());
      end
      if (s_finished) begin
        if (s_exp_frames.size() == 0) check("small_unexpected_frame", 1, 0);
        else cmp_frame("small", s_exp_frames.pop_front(), s_len, s_er, s_ex, s_cr, s_cv);
        s_in = 0;
        s_done_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int len, input int nrows);
    frame_exp_t e;
    e.len = len; e.er = 5; e.ex = 255; e.cr = 1; e.cv = 256;
    exp_frames.push_back(e);
    for (int r = 0; r < nrows; r++) exp_rows.push_back(r);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      step();
      n++;
    end
    check("frame_done_in_time", int'(done_cnt >= target), 1);
  endtask

  task automatic wait_row(input int r);
    int n = 0;
    while (int'(row_sel) != r && n < 2000) begin
      step();
      n++;
    end
    check("reach_row", int'(row_sel), r);
  endtask

  initial begin
    #300_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    frame_exp_t se;
    int n;
    #1 rst = 1'b1;
    #2;
    check("reset_busy", int'(busy), 0);
    check("reset_outputs", int'({erase, expose, cnt_rst, convert, read, valid, finished}), 0);
    check("reset_row_select", int'(row_sel), 0);
    step(); step();
    rst = 1'b0;
    step();
    check("idle_busy", int'(busy), 0);

    // Single frame, defaults
    push_frame(774, 128);
    pulse_start();
    check("erase_on_start_edge", int'(erase), 1);
    check("busy_on_start_edge", int'(busy), 1);
    wait_frames(1);
    check("idle_after_frame", int'(busy), 0);

    // Minimum-parameter sweep
    se.len = 9; se.er = 1; se.ex = 1; se.cr = 1; se.cv = 1;
    s_exp_frames.push_back(se);
    s_exp_rows.push_back(0);
    s_exp_rows.push_back(1);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    n = 0;
    while (s_done_cnt < 1 && n < 50) begin
      step();
      n++;
    end
    check("small_done_in_time", s_done_cnt, 1);
    check("small_idle_after", int'(s_busy), 0);

    // Backpressure on row 5
    push_frame(777, 128);
    pulse_start();
    wait_row(5);
    accept = 1'b0;
    repeat (4) step();
    check("bp_valid_held", int'(valid), 1);
    check("bp_row_held", int'(row_sel), 5);
    accept = 1'b1;
    wait_frames(2);

    // Continuous back-to-back frames
    continuous = 1'b1;
    push_frame(774, 128);
    push_frame(774, 128);
    pulse_start();
    wait_frames(3);
    check("cont_restart_erase", int'(erase), 1);
    continuous = 1'b0;
    wait_frames(4);
    check("cont_idle_after", int'(busy), 0);

    // START and ROW_ACCEPT activity in the wrong states is ignored
    push_frame(774, 128);
    pulse_start();
    n = 0;
    while (!expose && n < 50) begin step(); n++; end
    check("reach_expose", int'(expose), 1);
    start = 1'b1; step(); start = 1'b0; step(); start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!convert && n < 400) begin step(); n++; end
    check("reach_convert", int'(convert), 1);
    accept = 1'b0; step(); accept = 1'b1; step(); accept = 1'b0; step(); accept = 1'b1;
    wait_frames(5);

    // Reset during ROW_OFFER on row 60
    for (int r = 0; r < 60; r++) exp_rows.push_back(r);
    pulse_start();
    wait_row(60);
    accept = 1'b0;
    step(); step();
    check("offer_row60_valid", int'(valid), 1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          int'({erase, expose, cnt_rst, convert, read, valid, busy, finished}), 0);
    check("async_reset_row", int'(row_sel), 0);
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    check("idle_after_reset", int'(busy), 0);
    accept = 1'b1;
    push_frame(774, 128);
    pulse_start();
    wait_frames(6);

    step();
    check("rows_left", exp_rows.size(), 0);
    check("frames_left", exp_frames.size(), 0);
    check("small_rows_left", s_exp_rows.size(), 0);
    check("small_frames_left", s_exp_frames.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
